// File: rtl/pac_buf_arb_pkg.sv
// Shared widths, FSM state and pipeline-stage types for the packet-counter buffer arbiter.
package ctrl_signal_types;

   localparam int SRAM_DATA_WIDTH = 64;
   localparam int SRAM_ADDR_WIDTH = 4;
   localparam int CNT_W           = 32;
   localparam int NUM_SLOTS       = SRAM_DATA_WIDTH / CNT_W;
   localparam int SLOT_W          = $clog2(NUM_SLOTS);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } pac_arb_state_t;

   typedef enum logic {
      OP_UPD  = 1'b0,
      OP_HOST = 1'b1
   } pac_op_t;

   // One accepted operation waiting for its SRAM read data.
   typedef struct packed {
      logic                       valid;
      pac_op_t                    op;
      logic [SRAM_ADDR_WIDTH-1:0] addr;
      logic [SLOT_W-1:0]          slot;
      logic                       clear;
   } pac_s1_t;

endpackage

// File: rtl/pac_buf_arb_if.sv
// Client-side bundle of pac_buf_arb: counter-update request port and host read/clear port.
interface pac_buf_arb_if;
   import ctrl_signal_types::*;

   logic                       u_valid;
   logic                       u_ready;
   logic [SRAM_ADDR_WIDTH-1:0] u_addr;
   logic [SLOT_W-1:0]          u_slot;

   logic                       h_valid;
   logic                       h_ready;
   logic [SRAM_ADDR_WIDTH-1:0] h_addr;
   logic                       h_clear;
   logic                       h_rvalid;
   logic [SRAM_DATA_WIDTH-1:0] h_rdata;

   modport master (
      output u_valid, u_addr, u_slot, h_valid, h_addr, h_clear,
      input  u_ready, h_ready, h_rvalid, h_rdata
   );

   modport slave (
      input  u_valid, u_addr, u_slot, h_valid, h_addr, h_clear,
      output u_ready, h_ready, h_rvalid, h_rdata
   );

endinterface

// File: rtl/pac_buf_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins, the pointer breaks ties.
module pac_rr_arb2 (
   input  logic i_valid_u,
   input  logic i_valid_h,
   input  logic i_ptr,
   output logic o_grant_u,
   output logic o_grant_h
);

   // i_ptr = 0 favours the update requester, 1 favours the host requester.
   assign o_grant_u = i_valid_u & (~i_valid_h | ~i_ptr);
   assign o_grant_h = i_valid_h & (~i_valid_u |  i_ptr);

endmodule

// File: rtl/pac_buf_arb.sv
// Packet-counter buffer arbiter: zeroes the external counter SRAM after reset, then arbitrates
// slot increments against host reads. Define PAC_SAT_EN for saturating counters and sat_hit.
module pac_buf_arb
   import ctrl_signal_types::*;
(
   input  logic                       clock,
   input  logic                       reset_n,
   pac_buf_arb_if.slave               bus,
   output logic [SRAM_ADDR_WIDTH-1:0] buf_rdaddress,
   output logic [SRAM_ADDR_WIDTH-1:0] buf_wraddress,
   output logic                       buf_wren,
   output logic [SRAM_DATA_WIDTH-1:0] buf_data,
   input  logic [SRAM_DATA_WIDTH-1:0] buf_q,
`ifdef PAC_SAT_EN
   output logic                       sat_hit,
`endif
   output logic                       init_done
);

   pac_arb_state_t             r_state;
   logic [SRAM_ADDR_WIDTH-1:0] r_init_addr;
   logic                       r_rr_ptr;
   pac_s1_t                    r_s1;

   logic                       w_run;
   logic                       w_grant_u;
   logic                       w_grant_h;
   logic                       w_acc_u;
   logic                       w_acc_h;
   logic                       w_s1_upd;
   logic                       w_s1_host;
   logic [SRAM_DATA_WIDTH-1:0] w_inc_data;
   logic [CNT_W-1:0]           w_cnt;
`ifdef PAC_SAT_EN
   logic                       w_sat;
`endif

   assign w_run = (r_state == ST_RUN);

   pac_rr_arb2 u_rr_arb2 (
      .i_valid_u (bus.u_valid),
      .i_valid_h (bus.h_valid),
      .i_ptr     (r_rr_ptr),
      .o_grant_u (w_grant_u),
      .o_grant_h (w_grant_h)
   );

   assign bus.u_ready = w_run & w_grant_u;
   assign bus.h_ready = w_run & w_grant_h;
   assign w_acc_u     = bus.u_valid & bus.u_ready;
   assign w_acc_h     = bus.h_valid & bus.h_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_INIT;
         r_init_addr <= '0;
      end else if (r_state == ST_INIT) begin
         r_init_addr <= r_init_addr + SRAM_ADDR_WIDTH'(1);
         if (&r_init_addr) begin
            r_state <= ST_RUN;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= 1'b0;
         r_s1     <= '0;
      end else begin
         if (w_run & bus.u_valid & bus.h_valid) begin
            r_rr_ptr <= ~r_rr_ptr;
         end
         r_s1.valid <= w_acc_u | w_acc_h;
         if (w_acc_u | w_acc_h) begin
            r_s1.op    <= w_acc_h ? OP_HOST : OP_UPD;
            r_s1.addr  <= w_acc_h ? bus.h_addr : bus.u_addr;
            r_s1.slot  <= bus.u_slot;
            r_s1.clear <= w_acc_h & bus.h_clear;
         end
      end
   end

   always_comb begin
      buf_rdaddress = '0;
      if (w_acc_u) begin
         buf_rdaddress = bus.u_addr;
      end else if (w_acc_h) begin
         buf_rdaddress = bus.h_addr;
      end
   end

   always_comb begin
      w_inc_data = buf_q;
      w_cnt      = '0;
`ifdef PAC_SAT_EN
      w_sat      = 1'b0;
`endif
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (r_s1.slot == SLOT_W'(i)) begin
            w_cnt = buf_q[i*CNT_W +: CNT_W];
`ifdef PAC_SAT_EN
            if (&w_cnt) begin
               w_sat = 1'b1;
            end else begin
               w_cnt = w_cnt + CNT_W'(1);
            end
`else
            w_cnt = w_cnt + CNT_W'(1);
`endif
            w_inc_data[i*CNT_W +: CNT_W] = w_cnt;
         end
      end
   end

   assign w_s1_upd  = r_s1.valid & (r_s1.op == OP_UPD);
   assign w_s1_host = r_s1.valid & (r_s1.op == OP_HOST);

   // The zeroing sweep would otherwise drive buf_wren while reset is held, since reset parks
   // the FSM in ST_INIT.
   always_comb begin
      buf_wren      = 1'b0;
      buf_wraddress = '0;
      buf_data      = '0;
      if (reset_n) begin
         if (r_state == ST_INIT) begin
            buf_wren      = 1'b1;
            buf_wraddress = r_init_addr;
         end else if (w_s1_upd) begin
            buf_wren      = 1'b1;
            buf_wraddress = r_s1.addr;
            buf_data      = w_inc_data;
         end else if (w_s1_host && r_s1.clear) begin
            buf_wren      = 1'b1;
            buf_wraddress = r_s1.addr;
         end
      end
   end

   assign bus.h_rvalid = w_s1_host;
   assign bus.h_rdata  = w_s1_host ? buf_q : '0;
   assign init_done    = w_run;

`ifdef PAC_SAT_EN
   assign sat_hit = w_s1_upd & w_sat;
`endif

endmodule

// File: tb/tb_pac_buf_arb.sv
// Self-checking bench for pac_buf_arb with an SRAM model and a per-slot counter reference model.
// Build with PAC_SAT_EN defined to exercise the saturating variant.
module tb_pac_buf_arb;
   import ctrl_signal_types::*;

   localparam int AW    = SRAM_ADDR_WIDTH;
   localparam int DW    = SRAM_DATA_WIDTH;
   localparam int DEPTH = 2 ** AW;
`ifdef PAC_SAT_EN
   localparam logic [CNT_W-1:0] WRAP_EXP = 32'hFFFF_FFFF;
`else
   localparam logic [CNT_W-1:0] WRAP_EXP = 32'h0000_0000;
`endif

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   pac_buf_arb_if bus_if ();

   logic [AW-1:0] buf_rdaddress;
   logic [AW-1:0] buf_wraddress;
   logic          buf_wren;
   logic [DW-1:0] buf_data;
   logic [DW-1:0] buf_q;
   logic          init_done;
`ifdef PAC_SAT_EN
   logic          sat_hit;
`endif

   pac_buf_arb u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .bus           (bus_if),
      .buf_rdaddress (buf_rdaddress),
      .buf_wraddress (buf_wraddress),
      .buf_wren      (buf_wren),
      .buf_data      (buf_data),
      .buf_q         (buf_q),
`ifdef PAC_SAT_EN
      .sat_hit       (sat_hit),
`endif
      .init_done     (init_done)
   );

   // Counter SRAM: registered read, write-through on same-cycle address match, preload port.
   logic [DW-1:0] sram [DEPTH];
   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   always @(posedge clock) begin
      if (buf_wren) sram[buf_wraddress] <= buf_data;
      else if (pre_en) sram[pre_addr] <= pre_data;
      buf_q <= (buf_wren && buf_wraddress == buf_rdaddress) ? buf_data : sram[buf_rdaddress];
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain counters per word/slot, ops applied in acceptance order.
   bit [CNT_W-1:0] mdl [DEPTH][NUM_SLOTS];
   bit             mdl_run;
   bit             mdl_ptr;
   bit             pend_rv, pend_wr;
   logic [DW-1:0]  pend_rd, pend_wd;
   logic [AW-1:0]  pend_wa;
   bit             exp_rv, exp_wr, exp_ur, exp_hr;
   logic [DW-1:0]  exp_rd, exp_wd;
   logic [AW-1:0]  exp_wa, exp_ra;
`ifdef PAC_SAT_EN
   bit             pend_sat, exp_sat;
`endif

   function automatic logic [DW-1:0] mdl_word(input int a);
      logic [DW-1:0] w;
      for (int s = 0; s < NUM_SLOTS; s++) w[s*CNT_W +: CNT_W] = mdl[a][s];
      return w;
   endfunction

   task automatic mdl_reset();
      for (int a = 0; a < DEPTH; a++)
         for (int s = 0; s < NUM_SLOTS; s++) mdl[a][s] = '0;
      mdl_run = 1'b0; mdl_ptr = 1'b0;
      pend_rv = 1'b0; pend_wr = 1'b0; pend_rd = '0; pend_wd = '0; pend_wa = '0;
`ifdef PAC_SAT_EN
      pend_sat = 1'b0;
`endif
   endtask

   task automatic drive(input bit uv, input int ua, input int us,
                        input bit hv, input int ha, input bit hc);
      @(posedge clock);
      #1;
      bus_if.u_valid = uv; bus_if.u_addr = AW'(ua); bus_if.u_slot = SLOT_W'(us);
      bus_if.h_valid = hv; bus_if.h_addr = AW'(ha); bus_if.h_clear = hc;
   endtask

   // Mid-cycle: expose what the model expects now, then apply this cycle's grant to the model.
   task automatic step();
      int ua, us, ha;
      @(negedge clock);
      exp_rv = pend_rv; exp_rd = pend_rd; exp_wr = pend_wr; exp_wa = pend_wa; exp_wd = pend_wd;
`ifdef PAC_SAT_EN
      exp_sat = pend_sat; pend_sat = 1'b0;
`endif
      ua = int'(bus_if.u_addr); us = int'(bus_if.u_slot); ha = int'(bus_if.h_addr);
      exp_ur = mdl_run && bus_if.u_valid && (!bus_if.h_valid || !mdl_ptr);
      exp_hr = mdl_run && bus_if.h_valid && (!bus_if.u_valid || mdl_ptr);
      if (mdl_run && bus_if.u_valid && bus_if.h_valid) mdl_ptr = !mdl_ptr;
      exp_ra = exp_ur ? bus_if.u_addr : (exp_hr ? bus_if.h_addr : AW'(0));
      pend_rv = exp_hr; pend_wr = 1'b0; pend_rd = '0; pend_wa = '0; pend_wd = '0;
      if (exp_ur) begin
`ifdef PAC_SAT_EN
         if (mdl[ua][us] == '1) pend_sat = 1'b1;
         else mdl[ua][us] = mdl[ua][us] + 1'b1;
`else
         mdl[ua][us] = mdl[ua][us] + 1'b1;
`endif
         pend_wr = 1'b1; pend_wa = bus_if.u_addr; pend_wd = mdl_word(ua);
      end
      if (exp_hr) begin
         pend_rd = mdl_word(ha);
         if (bus_if.h_clear) begin
            for (int s = 0; s < NUM_SLOTS; s++) mdl[ha][s] = '0;
            pend_wr = 1'b1; pend_wa = bus_if.h_addr; pend_wd = '0;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus_if.u_valid = 1'b1; bus_if.u_addr = '0; bus_if.u_slot = '0;
      bus_if.h_valid = 1'b1; bus_if.h_addr = '0; bus_if.h_clear = 1'b0;
      mdl_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if ({buf_wren, init_done, bus_if.u_ready, bus_if.h_ready, bus_if.h_rvalid} !== 5'b0 ||
          buf_wraddress !== '0 || buf_data !== '0 || bus_if.h_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got wren=%b done=%b ur=%b hr=%b rv=%b wa=%h wd=%h rd=%h, want all 0",
                  buf_wren, init_done, bus_if.u_ready, bus_if.h_ready, bus_if.h_rvalid,
                  buf_wraddress, buf_data, bus_if.h_rdata);
      end
`ifdef PAC_SAT_EN
      n_checks++;
      if (sat_hit !== 1'b0) begin
         n_fail++; $display("FAIL reset_sat_hit: got %b want 0", sat_hit);
      end
`endif
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clock);
         n_checks++;
         if (buf_wren !== 1'b1 || buf_wraddress !== AW'(k) || buf_data !== '0 ||
             init_done !== 1'b0 || bus_if.u_ready !== 1'b0 || bus_if.h_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_sweep[%0d]: got wren=%b wa=%0d wd=%h done=%b ur=%b hr=%b, want 1 %0d 0 0 0 0",
                     k, buf_wren, buf_wraddress, buf_data, init_done, bus_if.u_ready,
                     bus_if.h_ready, k);
         end
      end
      @(posedge clock);
      #1 bus_if.u_valid = 1'b0; bus_if.h_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (init_done !== 1'b1 || buf_wren !== 1'b0 || buf_rdaddress !== '0) begin
         n_fail++;
         $display("FAIL init_done_rise: got done=%b wren=%b ra=%0d, want 1 0 0",
                  init_done, buf_wren, buf_rdaddress);
      end
      mdl_run = 1'b1;
   endtask

   task automatic test_contention();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1, 0, 1'b1, 2, 1'b0);
         step();
         n_checks++;
         if ({bus_if.u_ready, bus_if.h_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rr_alternate[%0d]: got ur/hr=%b%b want %s",
                     i, bus_if.u_ready, bus_if.h_ready, (i % 2 == 0) ? "10" : "01");
         end
         n_checks++;
         if (buf_rdaddress !== ((i % 2 == 0) ? AW'(1) : AW'(2))) begin
            n_fail++;
            $display("FAIL rr_rdaddr[%0d]: got %0d want %0d", i, buf_rdaddress,
                     (i % 2 == 0) ? 1 : 2);
         end
      end
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (bus_if.h_rvalid !== 1'b1 || bus_if.h_rdata !== exp_rd) begin
         n_fail++;
         $display("FAIL rr_last_read: got rv=%b rd=%h want 1 %h", bus_if.h_rvalid,
                  bus_if.h_rdata, exp_rd);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 5, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (bus_if.u_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_accept0: got ur=%b want 1", bus_if.u_ready);
      end
      drive(1'b1, 5, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (bus_if.u_ready !== 1'b1 || buf_wren !== 1'b1 || buf_wraddress !== AW'(5) ||
          buf_rdaddress !== AW'(5)) begin
         n_fail++;
         $display("FAIL b2b_no_stall: got ur=%b wren=%b wa=%0d ra=%0d want 1 1 5 5",
                  bus_if.u_ready, buf_wren, buf_wraddress, buf_rdaddress);
      end
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (buf_wren !== 1'b1 || buf_data !== exp_wd || buf_data[CNT_W-1:0] !== 32'd2) begin
         n_fail++;
         $display("FAIL b2b_second_write: got wren=%b wd=%h want 1 %h", buf_wren, buf_data, exp_wd);
      end
      drive(1'b0, 0, 0, 1'b1, 5, 1'b0);
      step();
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (bus_if.h_rvalid !== 1'b1 || bus_if.h_rdata[CNT_W-1:0] !== 32'd2) begin
         n_fail++;
         $display("FAIL b2b_readback: got rv=%b slot0=%0d want 1 2", bus_if.h_rvalid,
                  bus_if.h_rdata[CNT_W-1:0]);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 7, 1, 1'b0, 0, 1'b0);
         step();
      end
      drive(1'b0, 0, 0, 1'b1, 7, 1'b1);
      step();
      n_checks++;
      if (bus_if.h_ready !== 1'b1) begin
         n_fail++; $display("FAIL clear_accept: got hr=%b want 1", bus_if.h_ready);
      end
      drive(1'b0, 0, 0, 1'b1, 7, 1'b0);
      step();
      n_checks++;
      if (bus_if.h_rvalid !== 1'b1 || bus_if.h_rdata[CNT_W +: CNT_W] !== 32'd3 ||
          bus_if.h_rdata !== exp_rd) begin
         n_fail++;
         $display("FAIL clear_read: got rv=%b rd=%h want 1 %h (slot1=3)", bus_if.h_rvalid,
                  bus_if.h_rdata, exp_rd);
      end
      n_checks++;
      if (buf_wren !== 1'b1 || buf_wraddress !== AW'(7) || buf_data !== '0) begin
         n_fail++;
         $display("FAIL clear_write: got wren=%b wa=%0d wd=%h want 1 7 0", buf_wren,
                  buf_wraddress, buf_data);
      end
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (bus_if.h_rvalid !== 1'b1 || bus_if.h_rdata !== '0) begin
         n_fail++;
         $display("FAIL clear_second_read: got rv=%b rd=%h want 1 0", bus_if.h_rvalid,
                  bus_if.h_rdata);
      end
   endtask

   task automatic test_wrap();
      @(posedge clock);
      #1;
      pre_en = 1'b1; pre_addr = AW'(9); pre_data = '0; pre_data[CNT_W-1:0] = '1;
      for (int s = 0; s < NUM_SLOTS; s++) mdl[9][s] = '0;
      mdl[9][0] = '1;
      drive(1'b1, 9, 0, 1'b0, 0, 1'b0);
      pre_en = 1'b0;
      step();
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (buf_wren !== 1'b1 || buf_data[CNT_W-1:0] !== WRAP_EXP || buf_data !== exp_wd) begin
         n_fail++;
         $display("FAIL wrap_write: got wren=%b wd=%h want 1 %h", buf_wren, buf_data, exp_wd);
      end
`ifdef PAC_SAT_EN
      n_checks++;
      if (sat_hit !== 1'b1) begin
         n_fail++; $display("FAIL sat_hit_pulse: got %b want 1", sat_hit);
      end
`endif
      drive(1'b0, 0, 0, 1'b1, 9, 1'b0);
      step();
`ifdef PAC_SAT_EN
      n_checks++;
      if (sat_hit !== 1'b0) begin
         n_fail++; $display("FAIL sat_hit_one_cycle: got %b want 0", sat_hit);
      end
`endif
      drive(1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
      n_checks++;
      if (bus_if.h_rvalid !== 1'b1 || bus_if.h_rdata[CNT_W-1:0] !== WRAP_EXP) begin
         n_fail++;
         $display("FAIL wrap_readback: got rv=%b slot0=%h want 1 %h", bus_if.h_rvalid,
                  bus_if.h_rdata[CNT_W-1:0], WRAP_EXP);
      end
   endtask

   task automatic test_random();
      bit uv, hv, hc;
      int ua, us, ha;
      for (int c = 0; c <= 300; c++) begin
         uv = 1'($urandom_range(0, 1)); hv = 1'($urandom_range(0, 1));
         ua = int'($urandom_range(0, 3)); ha = int'($urandom_range(0, 3));
         us = int'($urandom_range(0, NUM_SLOTS - 1));
         hc = ($urandom_range(0, 3) == 0);
         if (c == 300) begin
            uv = 1'b0; hv = 1'b0;
         end
         drive(uv, ua, us, hv, ha, hc);
         step();
         n_checks++;
         if ({bus_if.u_ready, bus_if.h_ready} !== {exp_ur, exp_hr}) begin
            n_fail++;
            $display("FAIL rand_grant[%0d]: got ur/hr=%b%b want %b%b", c, bus_if.u_ready,
                     bus_if.h_ready, exp_ur, exp_hr);
         end
         n_checks++;
         if (buf_rdaddress !== exp_ra) begin
            n_fail++; $display("FAIL rand_rdaddr[%0d]: got %0d want %0d", c, buf_rdaddress, exp_ra);
         end
         n_checks++;
         if (bus_if.h_rvalid !== exp_rv) begin
            n_fail++; $display("FAIL rand_rvalid[%0d]: got %b want %b", c, bus_if.h_rvalid, exp_rv);
         end
         if (exp_rv) begin
            n_checks++;
            if (bus_if.h_rdata !== exp_rd) begin
               n_fail++;
               $display("FAIL rand_rdata[%0d]: got %h want %h", c, bus_if.h_rdata, exp_rd);
            end
         end
         n_checks++;
         if (buf_wren !== exp_wr) begin
            n_fail++; $display("FAIL rand_wren[%0d]: got %b want %b", c, buf_wren, exp_wr);
         end
         if (exp_wr) begin
            n_checks++;
            if (buf_wraddress !== exp_wa || buf_data !== exp_wd) begin
               n_fail++;
               $display("FAIL rand_write[%0d]: got wa=%0d wd=%h want %0d %h", c, buf_wraddress,
                        buf_data, exp_wa, exp_wd);
            end
         end
`ifdef PAC_SAT_EN
         n_checks++;
         if (sat_hit !== exp_sat) begin
            n_fail++; $display("FAIL rand_sat_hit[%0d]: got %b want %b", c, sat_hit, exp_sat);
         end
`endif
      end
   endtask

   task automatic test_reset_inflight();
      drive(1'b0, 0, 0, 1'b1, 3, 1'b1);
      step();
      n_checks++;
      if (bus_if.h_ready !== 1'b1) begin
         n_fail++; $display("FAIL inflight_accept: got hr=%b want 1", bus_if.h_ready);
      end
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      bus_if.u_valid = 1'b0; bus_if.h_valid = 1'b0; bus_if.h_clear = 1'b0;
      mdl_reset();
      @(negedge clock);
      n_checks++;
      if (buf_wren !== 1'b0 || bus_if.h_rvalid !== 1'b0 || init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL inflight_discard: got wren=%b rv=%b done=%b want 0 0 0", buf_wren,
                  bus_if.h_rvalid, init_done);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         n_checks++;
         if (buf_wren !== 1'b1 || buf_wraddress !== AW'(k) || buf_data !== '0) begin
            n_fail++;
            $display("FAIL sweep_restart[%0d]: got wren=%b wa=%0d wd=%h want 1 %0d 0", k,
                     buf_wren, buf_wraddress, buf_data, k);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      bus_if.u_valid = 1'b0; bus_if.u_addr = '0; bus_if.u_slot = '0;
      bus_if.h_valid = 1'b0; bus_if.h_addr = '0; bus_if.h_clear = 1'b0;
      test_reset();
      test_contention();
      test_back_to_back();
      test_clear();
      test_wrap();
      test_random();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
